// File: rtl/hazard_forward_unit_pkg.sv
// Shared definitions for the EX-stage forwarding/hazard unit.
//   fwd_sel_e : operand mux select encoding (mux data1..data4).
//               2'b11 is reserved and never driven.
package hazard_forward_unit_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,   // register-file value
        FWD_WB  = 2'b01,   // MEM/WB result
        FWD_MEM = 2'b10    // EX/MEM ALU result
    } fwd_sel_e;

endpackage

// File: rtl/hazard_forward_unit_if.sv
// Pipeline-side bus of the forwarding/hazard unit.
//   master : pipeline control (drives ID metadata and flush, reads selects/stall)
//   slave  : hazard_forward_unit
//   id_valid_i/id_rs1_i/id_rs2_i/id_rd_i/id_regwrite_i/id_memread_i : ID instr
//   flush_i     : kill the instruction entering ID/EX
//   fwd_a_o/b_o : src-A/B operand mux selects
//   stall_o     : load-use hazard, hold PC and IF/ID
//   stall_cnt_o : saturating stall-cycle count
interface hazard_forward_unit_if #(
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CNT_W  = 32
);
    logic              id_valid_i;
    logic [REG_AW-1:0] id_rs1_i;
    logic [REG_AW-1:0] id_rs2_i;
    logic [REG_AW-1:0] id_rd_i;
    logic              id_regwrite_i;
    logic              id_memread_i;
    logic              flush_i;
    logic [1:0]        fwd_a_o;
    logic [1:0]        fwd_b_o;
    logic              stall_o;
    logic [CNT_W-1:0]  stall_cnt_o;

    modport master (
        output id_valid_i, id_rs1_i, id_rs2_i, id_rd_i, id_regwrite_i,
               id_memread_i, flush_i,
        input  fwd_a_o, fwd_b_o, stall_o, stall_cnt_o
    );

    modport slave (
        input  id_valid_i, id_rs1_i, id_rs2_i, id_rd_i, id_regwrite_i,
               id_memread_i, flush_i,
        output fwd_a_o, fwd_b_o, stall_o, stall_cnt_o
    );
endinterface

// File: rtl/hazard_forward_unit_hz_stage_reg.sv
// One pipeline stage record {valid, rd, regwrite, memread}.
//   i_clk, i_rst_n : clock, async active-low reset (record cleared)
//   i_bubble       : load a bubble (valid/regwrite/memread = 0) instead of inputs
//   i_*            : record from the previous stage
//   o_*            : registered record
module hz_stage_reg #(
    parameter int unsigned REG_AW = 5
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_bubble,
    input  logic              i_valid,
    input  logic [REG_AW-1:0] i_rd,
    input  logic              i_regwrite,
    input  logic              i_memread,
    output logic              o_valid,
    output logic [REG_AW-1:0] o_rd,
    output logic              o_regwrite,
    output logic              o_memread
);
    logic              r_valid;
    logic [REG_AW-1:0] r_rd;
    logic              r_regwrite;
    logic              r_memread;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid    <= 1'b0;
            r_rd       <= '0;
            r_regwrite <= 1'b0;
            r_memread  <= 1'b0;
        end else if (i_bubble) begin
            r_valid    <= 1'b0;
            r_rd       <= i_rd;
            r_regwrite <= 1'b0;
            r_memread  <= 1'b0;
        end else begin
            r_valid    <= i_valid;
            r_rd       <= i_rd;
            r_regwrite <= i_regwrite;
            r_memread  <= i_memread;
        end
    end

    assign o_valid    = r_valid;
    assign o_rd       = r_rd;
    assign o_regwrite = r_regwrite;
    assign o_memread  = r_memread;
endmodule

// File: rtl/hazard_forward_unit.sv
// EX-stage operand forwarding control and load-use stall detection for a
// 5-stage RISC-V pipeline. Tracks destination metadata through ID/EX,
// EX/MEM and MEM/WB and counts stall cycles (saturating).
//   clk_i : clock, all state on rising edge
//   rst_i : asynchronous, active-low reset
//   bus   : hazard_forward_unit_if slave (ID metadata, flush, selects, stall)
module hazard_forward_unit
    import hazard_forward_unit_pkg::*;
#(
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CNT_W  = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    hazard_forward_unit_if.slave  bus
);
    logic              w_ex_valid, w_ex_regwrite, w_ex_memread;
    logic [REG_AW-1:0] w_ex_rd;
    logic              w_mem_valid, w_mem_regwrite, w_mem_memread;
    logic [REG_AW-1:0] w_mem_rd;
    logic              w_wb_valid, w_wb_regwrite, w_wb_memread;
    logic [REG_AW-1:0] w_wb_rd;
    logic [REG_AW-1:0] r_ex_rs1, r_ex_rs2;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic              w_stall, w_bubble;
    fwd_sel_e          w_fwd_a, w_fwd_b;

    // Stall and flush coincide into the same single bubble.
    assign w_stall  = bus.id_valid_i & w_ex_valid & w_ex_memread & (w_ex_rd != '0)
                    & ((w_ex_rd == bus.id_rs1_i) | (w_ex_rd == bus.id_rs2_i));
    assign w_bubble = w_stall | bus.flush_i;

    hz_stage_reg #(.REG_AW(REG_AW)) u_ex (
        .i_clk(clk_i), .i_rst_n(rst_i), .i_bubble(w_bubble),
        .i_valid(bus.id_valid_i), .i_rd(bus.id_rd_i),
        .i_regwrite(bus.id_regwrite_i), .i_memread(bus.id_memread_i),
        .o_valid(w_ex_valid), .o_rd(w_ex_rd),
        .o_regwrite(w_ex_regwrite), .o_memread(w_ex_memread)
    );

    hz_stage_reg #(.REG_AW(REG_AW)) u_mem (
        .i_clk(clk_i), .i_rst_n(rst_i), .i_bubble(1'b0),
        .i_valid(w_ex_valid), .i_rd(w_ex_rd),
        .i_regwrite(w_ex_regwrite), .i_memread(w_ex_memread),
        .o_valid(w_mem_valid), .o_rd(w_mem_rd),
        .o_regwrite(w_mem_regwrite), .o_memread(w_mem_memread)
    );

    hz_stage_reg #(.REG_AW(REG_AW)) u_wb (
        .i_clk(clk_i), .i_rst_n(rst_i), .i_bubble(1'b0),
        .i_valid(w_mem_valid), .i_rd(w_mem_rd),
        .i_regwrite(w_mem_regwrite), .i_memread(w_mem_memread),
        .o_valid(w_wb_valid), .o_rd(w_wb_rd),
        .o_regwrite(w_wb_regwrite), .o_memread(w_wb_memread)
    );

    // EX source registers follow ID even when a bubble is inserted, so the
    // stalled consumer's operands are already visible in the bubble cycle.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_ex_rs1 <= '0;
            r_ex_rs2 <= '0;
        end else begin
            r_ex_rs1 <= bus.id_rs1_i;
            r_ex_rs2 <= bus.id_rs2_i;
        end
    end

    // MEM result has priority over WB; x0 and bubbles never forward.
    function automatic fwd_sel_e fwd_select(input logic [REG_AW-1:0] rs);
        fwd_sel_e sel;
        sel = FWD_RF;
        if (w_mem_valid && w_mem_regwrite && (w_mem_rd != '0) && (w_mem_rd == rs))
            sel = FWD_MEM;
        else if (w_wb_valid && w_wb_regwrite && (w_wb_rd != '0) && (w_wb_rd == rs))
            sel = FWD_WB;
        return sel;
    endfunction

    always_comb begin
        w_fwd_a = fwd_select(r_ex_rs1);
        w_fwd_b = fwd_select(r_ex_rs2);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)
            r_stall_cnt <= '0;
        else if (w_stall && (r_stall_cnt != '1))
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end

    assign bus.fwd_a_o     = w_fwd_a;
    assign bus.fwd_b_o     = w_fwd_b;
    assign bus.stall_o     = w_stall;
    assign bus.stall_cnt_o = r_stall_cnt;

    // Load in MEM is forwarded like any ALU result; the stall guarantees
    // its data is ready, so its memread flag is not needed past EX.
    logic w_unused;
    assign w_unused = w_mem_memread ^ w_wb_memread;
endmodule

// File: tb/tb_hazard_forward_unit.sv
module tb_hazard_forward_unit;
    localparam int unsigned REG_AW = 5;
    localparam int unsigned CNT_W  = 4;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    hazard_forward_unit_if #(.REG_AW(REG_AW), .CNT_W(CNT_W)) bus ();

    hazard_forward_unit #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
        .clk_i(clk),
        .rst_i(rst_n),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 time unit after the rising edge; outputs are checked
    // 1 time unit later, well away from either edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [4:0] rd, input logic rw, input logic mr);
        bus.id_valid_i    = v;
        bus.id_rs1_i      = rs1;
        bus.id_rs2_i      = rs2;
        bus.id_rd_i       = rd;
        bus.id_regwrite_i = rw;
        bus.id_memread_i  = mr;
        #1;
    endtask

    task automatic flush_pipe();
        bus.flush_i = 1'b0;
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        repeat (3) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.flush_i = 1'b0;
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        #1;
        tests++;
        if (bus.stall_o !== 1'b0 || bus.fwd_a_o !== 2'b00 || bus.fwd_b_o !== 2'b00) begin
            fails++;
            $display("FAIL reset_outputs: stall=%b fwd_a=%b fwd_b=%b required 0/00/00",
                     bus.stall_o, bus.fwd_a_o, bus.fwd_b_o);
        end
        tests++;
        if (bus.stall_cnt_o !== 4'd0) begin
            fails++;
            $display("FAIL reset_cnt: got %0d required 0", bus.stall_cnt_o);
        end
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_fwd_mem();
        flush_pipe();
        set_id(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0);   // add x5
        tick();
        set_id(1'b1, 5'd5, 5'd6, 5'd10, 1'b1, 1'b0);  // add x10, x5, x6
        tests++;
        if (bus.stall_o !== 1'b0) begin
            fails++;
            $display("FAIL alu_no_stall: got %b required 0", bus.stall_o);
        end
        tick();
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        tests++;
        if (bus.fwd_a_o !== 2'b10 || bus.fwd_b_o !== 2'b00) begin
            fails++;
            $display("FAIL fwd_mem: fwd_a=%b fwd_b=%b required 10/00", bus.fwd_a_o, bus.fwd_b_o);
        end
    endtask

    task automatic test_fwd_wb();
        flush_pipe();
        set_id(1'b1, 5'd1, 5'd2, 5'd9, 1'b1, 1'b0);   // add x9
        tick();
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);   // empty slot
        tick();
        set_id(1'b1, 5'd9, 5'd3, 5'd11, 1'b1, 1'b0);  // uses x9
        tick();
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        tests++;
        if (bus.fwd_a_o !== 2'b01 || bus.fwd_b_o !== 2'b00) begin
            fails++;
            $display("FAIL fwd_wb: fwd_a=%b fwd_b=%b required 01/00", bus.fwd_a_o, bus.fwd_b_o);
        end
    endtask

    task automatic test_mem_priority();
        flush_pipe();
        set_id(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0);   // add x5 (older)
        tick();
        set_id(1'b1, 5'd3, 5'd4, 5'd5, 1'b1, 1'b0);   // add x5 (younger)
        tick();
        set_id(1'b1, 5'd1, 5'd5, 5'd12, 1'b1, 1'b0);  // rs2 = x5
        tick();
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        tests++;
        if (bus.fwd_b_o !== 2'b10 || bus.fwd_a_o !== 2'b00) begin
            fails++;
            $display("FAIL mem_priority: fwd_a=%b fwd_b=%b required 00/10", bus.fwd_a_o, bus.fwd_b_o);
        end
    endtask

    task automatic test_x0();
        flush_pipe();
        set_id(1'b1, 5'd1, 5'd2, 5'd0, 1'b1, 1'b0);   // writes x0
        tick();
        set_id(1'b1, 5'd0, 5'd0, 5'd13, 1'b1, 1'b0);  // reads x0
        tick();
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        tests++;
        if (bus.fwd_a_o !== 2'b00 || bus.fwd_b_o !== 2'b00) begin
            fails++;
            $display("FAIL x0_no_fwd: fwd_a=%b fwd_b=%b required 00/00", bus.fwd_a_o, bus.fwd_b_o);
        end
    endtask

    task automatic test_load_use();
        flush_pipe();
        set_id(1'b1, 5'd2, 5'd0, 5'd7, 1'b1, 1'b1);   // lw x7
        tick();
        set_id(1'b1, 5'd3, 5'd7, 5'd8, 1'b1, 1'b0);   // add x8, x3, x7
        tests++;
        if (bus.stall_o !== 1'b1 || bus.stall_cnt_o !== 4'd0) begin
            fails++;
            $display("FAIL load_use_stall: stall=%b cnt=%0d required 1/0", bus.stall_o, bus.stall_cnt_o);
        end
        tick();   // consumer held in ID
        tests++;
        if (bus.stall_o !== 1'b0 || bus.stall_cnt_o !== 4'd1) begin
            fails++;
            $display("FAIL load_use_release: stall=%b cnt=%0d required 0/1", bus.stall_o, bus.stall_cnt_o);
        end
        tests++;
        if (bus.fwd_b_o !== 2'b10) begin
            fails++;
            $display("FAIL load_use_fwd_mem: fwd_b=%b required 10", bus.fwd_b_o);
        end
        tick();   // consumer now in EX, load in MEM/WB
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        tests++;
        if (bus.fwd_b_o !== 2'b01 || bus.fwd_a_o !== 2'b00 || bus.stall_cnt_o !== 4'd1) begin
            fails++;
            $display("FAIL load_use_ex: fwd_a=%b fwd_b=%b cnt=%0d required 00/01/1",
                     bus.fwd_a_o, bus.fwd_b_o, bus.stall_cnt_o);
        end
    endtask

    task automatic test_flush_stall();
        flush_pipe();
        set_id(1'b1, 5'd1, 5'd2, 5'd4, 1'b1, 1'b0);   // add x4 (older)
        tick();
        set_id(1'b1, 5'd2, 5'd0, 5'd7, 1'b1, 1'b1);   // lw x7
        tick();
        bus.flush_i = 1'b1;
        set_id(1'b1, 5'd4, 5'd7, 5'd8, 1'b1, 1'b0);   // uses x4 and x7
        tests++;
        if (bus.stall_o !== 1'b1 || bus.stall_cnt_o !== 4'd1) begin
            fails++;
            $display("FAIL flush_stall_on: stall=%b cnt=%0d required 1/1", bus.stall_o, bus.stall_cnt_o);
        end
        tick();
        bus.flush_i = 1'b0;
        #1;
        tests++;
        if (bus.stall_o !== 1'b0 || bus.stall_cnt_o !== 4'd2) begin
            fails++;
            $display("FAIL flush_stall_once: stall=%b cnt=%0d required 0/2", bus.stall_o, bus.stall_cnt_o);
        end
        tests++;
        if (bus.fwd_a_o !== 2'b01 || bus.fwd_b_o !== 2'b10) begin
            fails++;
            $display("FAIL flush_stall_fwd: fwd_a=%b fwd_b=%b required 01/10", bus.fwd_a_o, bus.fwd_b_o);
        end
    endtask

    task automatic test_saturation();
        logic [3:0] prev;
        flush_pipe();
        prev = bus.stall_cnt_o;
        set_id(1'b1, 5'd7, 5'd0, 5'd7, 1'b1, 1'b1);   // lw x7, 0(x7) repeatedly
        for (int i = 0; i < 40; i++) begin
            tick();
            tests++;
            if (bus.stall_cnt_o < prev) begin
                fails++;
                $display("FAIL sat_monotonic: cycle %0d cnt=%0d below previous %0d", i, bus.stall_cnt_o, prev);
            end
            prev = bus.stall_cnt_o;
        end
        tests++;
        if (bus.stall_cnt_o !== 4'd15) begin
            fails++;
            $display("FAIL sat_max: got %0d required 15", bus.stall_cnt_o);
        end
        if (bus.stall_o == 1'b0) tick();
        tick();
        tick();
        tests++;
        if (bus.stall_cnt_o !== 4'd15) begin
            fails++;
            $display("FAIL sat_hold: got %0d required 15", bus.stall_cnt_o);
        end
    endtask

    task automatic test_reset_mid_stall();
        flush_pipe();
        set_id(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0);   // add x5
        tick();
        set_id(1'b1, 5'd5, 5'd0, 5'd7, 1'b1, 1'b1);   // lw x7, 0(x5)
        tick();
        set_id(1'b1, 5'd3, 5'd7, 5'd8, 1'b1, 1'b0);   // uses x7
        tests++;
        if (bus.stall_o !== 1'b1 || bus.fwd_a_o !== 2'b10) begin
            fails++;
            $display("FAIL pre_reset: stall=%b fwd_a=%b required 1/10", bus.stall_o, bus.fwd_a_o);
        end
        rst_n = 1'b0;
        #1;
        tests++;
        if (bus.stall_o !== 1'b0 || bus.fwd_a_o !== 2'b00 || bus.fwd_b_o !== 2'b00
            || bus.stall_cnt_o !== 4'd0) begin
            fails++;
            $display("FAIL async_reset: stall=%b fwd_a=%b fwd_b=%b cnt=%0d required 0/00/00/0",
                     bus.stall_o, bus.fwd_a_o, bus.fwd_b_o, bus.stall_cnt_o);
        end
        tick();
        rst_n = 1'b1;
        set_id(1'b1, 5'd2, 5'd0, 5'd7, 1'b1, 1'b1);   // lw x7
        tick();                                        // first edge after release
        set_id(1'b1, 5'd7, 5'd0, 5'd9, 1'b1, 1'b0);
        tests++;
        if (bus.stall_o !== 1'b1 || bus.stall_cnt_o !== 4'd0) begin
            fails++;
            $display("FAIL post_reset_load: stall=%b cnt=%0d required 1/0", bus.stall_o, bus.stall_cnt_o);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_fwd_mem();
        test_fwd_wb();
        test_mem_priority();
        test_x0();
        test_load_use();
        test_flush_stall();
        test_saturation();
        test_reset_mid_stall();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
